// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_e   : arbiter FSM states (normal CPU priority / forced DMA slot)
//   arb_gnt_e     : which requester owns the memory port this cycle
//   WORD_OFS_MASK : byte-offset bits cleared to form a word address
package dmem_arb_pkg;

    typedef enum logic {
        ARB_NORMAL    = 1'b0,
        ARB_FORCE_DMA = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DMA  = 2'd2
    } arb_gnt_e;

    localparam logic [1:0] WORD_OFS_MASK = 2'b11;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: counts consecutive cycles a valid DMA request is denied.
//   clk, rst     : clock, synchronous active-high reset
//   dma_valid_i  : DMA request valid
//   dma_acc_i    : DMA request accepted this cycle
//   hit_o        : this cycle's denial brings the count to STARVE_LIMIT
module arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_valid_i,
    input  logic dma_acc_i,
    output logic hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             deny;

    always_comb begin
        deny  = dma_valid_i & ~dma_acc_i;
        cnt_d = '0;
        if (deny) begin
            cnt_d = (cnt_q != CNT_W'(STARVE_LIMIT)) ? cnt_q + CNT_W'(1) : cnt_q;
        end
        // Fires on the denial that takes the count from LIMIT-1 to LIMIT.
        hit_o = deny && (cnt_q == CNT_W'(STARVE_LIMIT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage and
// a DMA/debug requester. CPU has priority; a starvation counter forces one
// DMA slot (stalling the pipeline if the CPU wanted the port).
//   clk, rst                          : clock, synchronous active-high reset
//   cpu_re/we/addr/wdata, cpu_rdata   : MEM-stage access, combinational read data
//   cpu_stall                         : freeze request to the hazard unit
//   dma_valid/we/addr/wdata, dma_ready: DMA request handshake
//   dma_rvalid, dma_rdata             : registered one-cycle read response
//   mem_a/we/wd, mem_rd               : DataMem port
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_valid,
    output logic              dma_ready,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_OFS_MASK);

    arb_state_e        state_q, state_d;
    arb_gnt_e          gnt;
    logic              cpu_req;
    logic              dma_acc;
    logic              starve_hit;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign cpu_req = cpu_re | cpu_we;
    assign dma_acc = dma_valid & dma_ready;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .dma_valid_i(dma_valid),
        .dma_acc_i  (dma_acc),
        .hit_o      (starve_hit)
    );

    // Grant and handshake outputs. Kept apart from next-state so the
    // ready -> counter -> hit path does not loop back into this block.
    always_comb begin
        gnt       = GNT_NONE;
        dma_ready = 1'b0;
        cpu_stall = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ARB_NORMAL: begin
                    if (cpu_req) begin
                        gnt = GNT_CPU;
                    end else if (dma_valid) begin
                        gnt       = GNT_DMA;
                        dma_ready = 1'b1;
                    end
                end
                ARB_FORCE_DMA: begin
                    gnt       = GNT_DMA;
                    dma_ready = dma_valid;
                    cpu_stall = cpu_req;
                end
                default: gnt = GNT_NONE;
            endcase
        end
    end

    always_comb begin
        state_d = ARB_NORMAL;
        if (state_q == ARB_NORMAL && starve_hit) begin
            state_d = ARB_FORCE_DMA;
        end
    end

    // Memory port mux; a wasted forced slot (no dma_valid) must not write.
    always_comb begin
        mem_a  = cpu_addr;
        mem_we = 1'b0;
        mem_wd = cpu_wdata;
        case (gnt)
            GNT_CPU: begin
                mem_a  = cpu_addr & ALIGN_MASK;
                mem_we = cpu_we;
                mem_wd = cpu_wdata;
            end
            GNT_DMA: begin
                mem_a  = dma_addr & ALIGN_MASK;
                mem_we = dma_we & dma_valid;
                mem_wd = dma_wdata;
            end
            default: mem_we = 1'b0;
        endcase
    end

    always_comb begin
        rvalid_d = dma_acc & ~dma_we;
        rdata_d  = rvalid_d ? mem_rd : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_NORMAL;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cpu_rdata  = mem_rd;
    // A response already registered when rst rises is suppressed, not shown.
    assign dma_rvalid = rvalid_q & ~rst;
    assign dma_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic for dmem_arbiter,
// checked every cycle against a transaction-level model with its own memory.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_re, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_valid, dma_ready, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W(32),
        .ADDR_W(32),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // DataMem stand-in: combinational read, write on the clock edge.
    logic [31:0] tb_mem  [0:63];
    logic [31:0] ref_mem [0:63];

    assign mem_rd = tb_mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_a[7:2]] <= mem_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: who wins, how long DMA has been refused,
    // whether a forced slot is due, and the pending read response.
    int unsigned m_streak = 0;
    bit          m_force  = 0;
    bit          m_rv     = 0;
    logic [31:0] m_rd     = '0;

    always @(negedge clk) begin
        int          winner;  // 0 none, 1 cpu, 2 dma
        bit          creq, acc, e_we;
        logic [31:0] e_a, e_wd;
        creq = cpu_re || cpu_we;
        if (rst) begin
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_ready", 32'(dma_ready), 0);
            chk("rst_stall", 32'(cpu_stall), 0);
            chk("rst_rvalid", 32'(dma_rvalid), 0);
            m_streak = 0;
            m_force  = 0;
            m_rv     = 0;
            m_rd     = '0;
        end else begin
            if (m_force)        winner = 2;
            else if (creq)      winner = 1;
            else if (dma_valid) winner = 2;
            else                winner = 0;
            acc  = (winner == 2) && dma_valid;
            e_we = (winner == 1) ? cpu_we : (acc && dma_we);
            e_wd = (winner == 1) ? cpu_wdata : dma_wdata;
            if (winner == 2)      e_a = {dma_addr[31:2], 2'b00};
            else if (winner == 1) e_a = {cpu_addr[31:2], 2'b00};
            else                  e_a = cpu_addr;

            chk("ready", 32'(dma_ready), 32'(acc));
            chk("stall", 32'(cpu_stall), 32'(m_force && creq));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_a", mem_a, e_a);
            if (e_we) chk("mem_wd", mem_wd, e_wd);
            chk("rvalid", 32'(dma_rvalid), 32'(m_rv));
            chk("rdata", dma_rdata, m_rd);
            chk("cpu_rdata_pass", cpu_rdata, mem_rd);
            if (winner == 1 && cpu_re) chk("cpu_load", cpu_rdata, ref_mem[cpu_addr[7:2]]);

            m_rv = acc && !dma_we;
            if (m_rv) m_rd = ref_mem[dma_addr[7:2]];
            if (winner == 1 && cpu_we) ref_mem[cpu_addr[7:2]] = cpu_wdata;
            else if (acc && dma_we)    ref_mem[dma_addr[7:2]] = dma_wdata;
            m_streak = (dma_valid && !acc) ? m_streak + 1 : 0;
            m_force  = !m_force && (m_streak >= LIM);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_valid = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    initial begin
        bit acc;
        int unsigned r;
        for (int i = 0; i < 64; i++) begin
            tb_mem[i]  = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        end
        tb_mem[4]  = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;

        // Reset with competing requests.
        idle();
        rst = 1; dma_valid = 1; dma_addr = 32'h10; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'h55;
        repeat (2) begin
            @(negedge clk);
            chk("d_rst_we", 32'(mem_we), 0);
            chk("d_rst_ready", 32'(dma_ready), 0);
            chk("d_rst_stall", 32'(cpu_stall), 0);
            chk("d_rst_rvalid", 32'(dma_rvalid), 0);
        end
        tick(); rst = 0; idle();
        @(negedge clk);
        chk("d_state_normal", 32'(dut.state_q), 32'(ARB_NORMAL));

        // Idle CPU, DMA read of word 4.
        tick(); dma_valid = 1; dma_we = 0; dma_addr = 32'h10;
        @(negedge clk); chk("d_rd_ready", 32'(dma_ready), 1);
        tick(); dma_valid = 0;
        @(negedge clk);
        chk("d_rd_rvalid", 32'(dma_rvalid), 1);
        chk("d_rd_data", dma_rdata, 32'hDEAD_BEEF);

        // CPU and DMA store to the same word; CPU first.
        tick();
        cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1111_1111;
        dma_valid = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h2222_2222;
        @(negedge clk);
        chk("d_pri_ready", 32'(dma_ready), 0);
        chk("d_pri_wd", mem_wd, 32'h1111_1111);
        tick(); cpu_we = 0;
        @(negedge clk);
        chk("d_pri_mem_cpu", tb_mem[8], 32'h1111_1111);
        chk("d_pri_ready2", 32'(dma_ready), 1);
        tick(); idle();
        @(negedge clk);
        chk("d_pri_mem_dma", tb_mem[8], 32'h2222_2222);

        // Starvation under continuous CPU loads.
        tick(); cpu_re = 1; cpu_addr = 32'h40; dma_valid = 1; dma_we = 0; dma_addr = 32'h10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("d_stv_denied", 32'(dma_ready), 0);
            chk("d_stv_nostall", 32'(cpu_stall), 0);
            tick();
        end
        @(negedge clk);
        chk("d_stv_ready", 32'(dma_ready), 1);
        chk("d_stv_stall", 32'(cpu_stall), 1);
        tick(); dma_valid = 0;
        @(negedge clk);
        chk("d_stv_unstall", 32'(cpu_stall), 0);
        chk("d_stv_rvalid", 32'(dma_rvalid), 1);
        chk("d_stv_rdata", dma_rdata, 32'hDEAD_BEEF);

        // Misaligned DMA write lands on the containing word.
        tick(); idle(); dma_valid = 1; dma_we = 1; dma_addr = 32'h23; dma_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("d_mis_ready", 32'(dma_ready), 1);
        chk("d_mis_a", mem_a, 32'h20);
        chk("d_mis_we", 32'(mem_we), 1);
        tick(); idle(); cpu_re = 1; cpu_addr = 32'h20;
        @(negedge clk); chk("d_mis_load", cpu_rdata, 32'hA5A5_A5A5);

        // Reset right after a DMA read accept drops the response.
        tick(); idle(); dma_valid = 1; dma_addr = 32'h10;
        @(negedge clk); chk("d_mr_ready", 32'(dma_ready), 1);
        tick(); dma_valid = 0; rst = 1;
        @(negedge clk); chk("d_mr_rvalid", 32'(dma_rvalid), 0);
        tick(); rst = 0;
        @(negedge clk);
        chk("d_mr_rvalid2", 32'(dma_rvalid), 0);
        chk("d_mr_cnt", 32'(dut.u_starve.cnt_q), 0);

        // Randomized traffic; DMA holds its request until accepted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = dma_valid && dma_ready;
            tick();
            rst = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 9);
            cpu_re    = (r < 4);
            cpu_we    = (r >= 4 && r < 7);
            cpu_addr  = 32'($urandom_range(0, 255));
            cpu_wdata = $urandom;
            if (!dma_valid || acc) begin
                if ($urandom_range(0, 9) < 6) begin
                    dma_valid = 1;
                    dma_we    = 1'($urandom_range(0, 1));
                    dma_addr  = 32'($urandom_range(0, 255));
                    dma_wdata = $urandom;
                end else begin
                    dma_valid = 0;
                end
            end
        end
        tick(); idle();
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the MEM stage (CPU port) and a DMA/debug requester (DMA port).
- Sits between Data_Cycle's memory interface and DataMem. DataMem has combinational read and a write that commits on the clock edge.
- The CPU has priority. A starvation counter guarantees DMA progress: on a forced DMA slot, the block drives cpu_stall to the hazard unit, which freezes IF through MEM for that cycle.

Parameters:
- DATA_W, 32, data width of both ports and the memory.
- ADDR_W, 32, byte-address width.
- STARVE_LIMIT, 4, number of consecutive denied DMA-valid cycles before a DMA grant is forced. Legal range is 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_re  in  1  MEM-stage load (ResultSrcM selects memory)
- cpu_we  in  1  MEM-stage store (MemWriteM)
- cpu_addr  in  ADDR_W  ALUResultM
- cpu_wdata  in  DATA_W  WriteDataM
- cpu_rdata  out  DATA_W  read data to the MEM/WB register, combinational from mem_rd
- cpu_stall  out  1  freeze request to the hazard unit
- dma_valid  in  1  DMA request valid
- dma_ready  out  1  DMA request accepted this cycle
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  DMA byte address
- dma_wdata  in  DATA_W  DMA write data
- dma_rvalid  out  1  read response valid, one-cycle pulse
- dma_rdata  out  DATA_W  registered read data
- mem_a  out  ADDR_W  to DataMem A
- mem_we  out  1  to DataMem WE_dm
- mem_wd  out  DATA_W  to DataMem WD_dm
- mem_rd  in  DATA_W  from DataMem RD_dm

Behaviour:
- Decided interface facts: one clock clk; reset rst is synchronous and active-high.
- Definitions:
  - cpu_req = cpu_re | cpu_we.
  - dma_acc = dma_valid & dma_ready.
- FSM states: NORMAL and FORCE_DMA.
- NORMAL:
  - cpu_req=1: grant CPU, dma_ready=0, cpu_stall=0.
  - cpu_req=0 and dma_valid=1: grant DMA, dma_ready=1.
  - cpu_stall is 0 in this state.
- FORCE_DMA:
  - Grant DMA unconditionally; dma_ready=1 if dma_valid.
  - cpu_stall=cpu_req.
  - A stalled CPU access is not performed: mem_we excludes cpu_we.
- Starvation counter starve_cnt:
  - Increments each cycle dma_valid=1 and dma_acc=0, saturating at STARVE_LIMIT.
  - Clears on dma_acc or when dma_valid=0.
- Transitions:
  - NORMAL -> FORCE_DMA at the clock edge where starve_cnt==STARVE_LIMIT-1 and the DMA is denied again (count reaches STARVE_LIMIT).
  - FORCE_DMA -> NORMAL after exactly one cycle, regardless of dma_valid. If the DMA dropped valid, the slot is wasted and cpu_stall still follows cpu_req.
- Memory mux, combinational:
  - mem_a = granted address with bits [1:0] forced to 0.
  - mem_we = granted write enable.
  - mem_wd = granted data.
  - With no grant: mem_we=0 and mem_a=cpu_addr.
- cpu_rdata = mem_rd at all times. The CPU uses it only when granted.
- DMA read response:
  - On dma_acc with dma_we=0, mem_rd is registered into dma_rdata.
  - dma_rvalid=1 the next cycle, for one cycle. DMA writes produce no rvalid.
  - Back-to-back DMA reads give consecutive rvalid pulses.
- Handshake: the DMA holds valid/we/addr/wdata stable until dma_ready. The block never revokes dma_ready within a cycle.
- Simultaneous events: a CPU store and a DMA store in the same NORMAL cycle resolve to the CPU; the DMA waits.
- Reset:
  - Sets state=NORMAL, starve_cnt=0, dma_rvalid=0, dma_rdata=0.
  - A response pending when rst asserts is dropped.
  - While rst=1, mem_we=0, dma_ready=0 and cpu_stall=0, overriding the grant logic.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (ARB_NORMAL, ARB_FORCE_DMA);
  - the grant encoding (GNT_NONE, GNT_CPU, GNT_DMA);
  - the word-align mask constant.
- Sub-module arb_starve_ctr: the saturating counter with limit-hit output, parameterised on STARVE_LIMIT, counter width $clog2(STARVE_LIMIT+1).
- The datapath mux stays inline.

Test Plan:
- Reset:
  - rst=1 for 2 cycles with dma_valid=1 and cpu_we=1 -> mem_we=0, dma_ready=0, cpu_stall=0, dma_rvalid=0.
  - After release, state is NORMAL.
- Idle CPU DMA read: cpu_req=0, DMA read at addr 0x00000010, memory word 4 = 0xDEADBEEF -> dma_ready=1 same cycle; next cycle dma_rvalid=1, dma_rdata=0xDEADBEEF.
- CPU priority: CPU store 0x11111111 to 0x20 and DMA store 0x22222222 to 0x20 in the same cycle -> memory holds 0x11111111; DMA accepted the next cycle; memory then holds 0x22222222.
- Starvation (STARVE_LIMIT=4): cpu_re=1 continuously, DMA read pending -> dma_ready=0 for 4 cycles; 5th cycle dma_ready=1 and cpu_stall=1; 6th cycle cpu_stall=0 and dma_rvalid=1.
- Misaligned DMA write: dma_addr=0x00000023, data 0xA5A5A5A5 -> mem_a=0x00000020; a CPU load of 0x20 returns 0xA5A5A5A5.
- Reset mid-response: rst asserted in the cycle after a DMA read accept -> dma_rvalid stays 0; starve_cnt=0.
